// File: rtl/register_bank_pkg.sv
// Shared pipeline package: register bank sizing and dump FSM encoding.
package register_bank_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

  typedef struct packed {
    logic valid;
    logic done;
  } dump_flags_t;

endpackage

// File: rtl/register_bank_dump_fsm.sv
// Debug dump sequencer: walks every register index while the pipeline is
// halted, one word per accepted handshake.
module register_bank_dump_fsm
  import register_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_halt,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  output logic                  o_dump_valid,
  output logic [ADDR_WIDTH-1:0] o_dump_index,
  output logic                  o_dump_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

  dump_state_e           state;
  logic [ADDR_WIDTH-1:0] idx;
  dump_flags_t           flags;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= DUMP_IDLE;
      idx   <= '0;
      flags <= '0;
    end else begin
      unique case (state)
        DUMP_IDLE: begin
          flags.done <= 1'b0;
          if (i_dump_start && i_halt) begin
            state       <= DUMP_SEND;
            idx         <= '0;
            flags.valid <= 1'b1;
          end
        end
        DUMP_SEND: begin
          // Losing halt abandons the dump silently.
          if (!i_halt) begin
            state       <= DUMP_IDLE;
            idx         <= '0;
            flags.valid <= 1'b0;
          end else if (i_dump_ready) begin
            if (idx == LAST_IDX) begin
              state       <= DUMP_DONE;
              idx         <= '0;
              flags.valid <= 1'b0;
              flags.done  <= 1'b1;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        DUMP_DONE: begin
          state       <= DUMP_IDLE;
          flags.done  <= 1'b0;
          flags.valid <= 1'b0;
        end
        default: begin
          state <= DUMP_IDLE;
          idx   <= '0;
          flags <= '0;
        end
      endcase
    end
  end

  assign o_dump_valid = flags.valid;
  assign o_dump_index = idx;
  assign o_dump_done  = flags.done;

endmodule

// File: rtl/register_bank.sv
// Integer register file with two combinational read ports and a debug dump.
// Define REGISTER_BANK_BYPASS_EN to forward same-cycle write data to reads.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_halt,
  input  logic                  i_reg_write,
  input  logic [ADDR_WIDTH-1:0] i_write_reg,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [ADDR_WIDTH-1:0] i_read_reg1,
  input  logic [ADDR_WIDTH-1:0] i_read_reg2,
  output logic [DATA_WIDTH-1:0] o_read_data1,
  output logic [DATA_WIDTH-1:0] o_read_data2,
  input  logic                  i_dump_start,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic [ADDR_WIDTH-1:0] o_dump_index,
  output logic                  o_dump_valid,
  input  logic                  i_dump_ready,
  output logic                  o_dump_done
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_en;
  logic                  dump_valid;
  logic [ADDR_WIDTH-1:0] dump_index;

  assign wr_en = i_reg_write && !i_halt && !i_reset
               && (i_write_reg != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[i_write_reg] <= i_write_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_port(
    input logic [ADDR_WIDTH-1:0] idx
  );
    logic [DATA_WIDTH-1:0] val;
    val = regs[idx];
`ifdef REGISTER_BANK_BYPASS_EN
    if (wr_en && (idx == i_write_reg)) begin
      val = i_write_data;
    end
`endif
    // r0 is hardwired regardless of what storage holds.
    if (idx == '0) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    o_read_data1 = rd_port(i_read_reg1);
    o_read_data2 = rd_port(i_read_reg2);
  end

  register_bank_dump_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dump (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_halt      (i_halt),
    .i_dump_start(i_dump_start),
    .i_dump_ready(i_dump_ready),
    .o_dump_valid(dump_valid),
    .o_dump_index(dump_index),
    .o_dump_done (o_dump_done)
  );

  assign o_dump_valid = dump_valid;
  assign o_dump_index = dump_index;
  assign o_dump_data  = dump_valid ? regs[dump_index] : '0;

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank.
// Inputs change at negedge; outputs are sampled at negedge or #1 later.
module tb_register_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk;
  logic          rst;
  logic          halt;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [AW-1:0] rd1;
  logic [AW-1:0] rd2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic          dump_start;
  logic [DW-1:0] dump_data;
  logic [AW-1:0] dump_index;
  logic          dump_valid;
  logic          dump_ready;
  logic          dump_done;

  int checks;
  int errors;
  logic [DW-1:0] exp_reg [NR];

  register_bank #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_halt      (halt),
    .i_reg_write (reg_write),
    .i_write_reg (write_reg),
    .i_write_data(write_data),
    .i_read_reg1 (rd1),
    .i_read_reg2 (rd2),
    .o_read_data1(rdata1),
    .o_read_data2(rdata2),
    .i_dump_start(dump_start),
    .o_dump_data (dump_data),
    .o_dump_index(dump_index),
    .o_dump_valid(dump_valid),
    .i_dump_ready(dump_ready),
    .o_dump_done (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    step();
    reg_write  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (dump_valid !== 1'b0 || dump_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b done=%b, want 0 0",
               dump_valid, dump_done);
    end
    checks++;
    if (dump_index !== '0 || dump_data !== '0) begin
      errors++;
      $display("FAIL reset_dump: idx=%0d data=%h, want 0 0",
               dump_index, dump_data);
    end
    for (int i = 0; i < NR; i++) begin
      rd1 = AW'(i);
      rd2 = AW'(NR - 1 - i);
      #1;
      checks++;
      if (rdata1 !== '0 || rdata2 !== '0) begin
        errors++;
        $display("FAIL reset_read r%0d: got %h/%h, want 0",
                 i, rdata1, rdata2);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    rd1 = 5;
    do_write(5, 32'hDEADBEEF);
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_r5: got %h, want deadbeef", rdata1);
    end
    do_write(31, 32'h0BAD_F00D);
    rd2 = 31;
    #1;
    checks++;
    if (rdata2 !== 32'h0BAD_F00D || rdata1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_r31: got %h/%h, want deadbeef/0badf00d",
               rdata1, rdata2);
    end
    @(negedge clk);
  endtask

  task automatic test_r0();
    do_write(0, 32'h12345678);
    rd1 = 0;
    rd2 = 0;
    #1;
    checks++;
    if (rdata1 !== '0 || rdata2 !== '0) begin
      errors++;
      $display("FAIL r0_write: got %h/%h, want 0", rdata1, rdata2);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
`ifdef REGISTER_BANK_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = 32'h1;
`endif
    do_write(7, 32'h1);
    rd2        = 7;
    reg_write  = 1'b1;
    write_reg  = 7;
    write_data = 32'hA5A5A5A5;
    #1;
    checks++;
    if (rdata2 !== want) begin
      errors++;
      $display("FAIL same_cycle_r7: got %h, want %h", rdata2, want);
    end
    @(negedge clk);
    reg_write = 1'b0;
    checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL after_write_r7: got %h, want a5a5a5a5", rdata2);
    end
  endtask

  task automatic test_halt();
    do_write(3, 32'h33);
    halt = 1'b1;
    do_write(3, 32'hFF);
    rd1 = 3;
    rd2 = 5;
    #1;
    checks++;
    if (rdata1 !== 32'h33 || rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL halt_write: got %h/%h, want 33/deadbeef",
               rdata1, rdata2);
    end
    @(negedge clk);
    halt = 1'b0;
  endtask

  task automatic test_dump();
    int n;
    int cyc;
    int pulses;
    exp_reg[0] = '0;
    for (int k = 1; k < NR; k++) begin
      exp_reg[k] = (32'(k) * 32'h01010101) ^ 32'hA5000000;
      do_write(AW'(k), exp_reg[k]);
    end
    // Start without halt must be ignored.
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    checks++;
    if (dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_no_halt: valid=%b, want 0", dump_valid);
    end
    halt       = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    n   = 0;
    cyc = 0;
    while (n < NR && cyc < 200) begin
      checks++;
      if (dump_valid !== 1'b1 || dump_index !== AW'(n)
          || dump_data !== exp_reg[n]) begin
        errors++;
        $display("FAIL dump_word %0d: v=%b idx=%0d data=%h, want 1 %0d %h",
                 n, dump_valid, dump_index, dump_data, n, exp_reg[n]);
      end
      dump_ready = (cyc % 2 == 0);
      step();
      if (dump_ready) n++;
      cyc++;
    end
    dump_ready = 1'b0;
    checks++;
    if (n != NR) begin
      errors++;
      $display("FAIL dump_timeout: got %0d words, want %0d", n, NR);
    end
    pulses = 0;
    checks++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_index !== '0
        || dump_data !== '0) begin
      errors++;
      $display("FAIL dump_done: done=%b v=%b idx=%0d data=%h, want 1 0 0 0",
               dump_done, dump_valid, dump_index, dump_data);
    end
    for (int i = 0; i < 4; i++) begin
      if (dump_done === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d, want 1", pulses);
    end
    halt = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int c;
    int seen_done;
    halt       = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    c = 0;
    while (dump_index !== AW'(10) && c < 50) begin
      step();
      c++;
    end
    checks++;
    if (dump_index !== AW'(10) || dump_data !== exp_reg[10]) begin
      errors++;
      $display("FAIL abort_reach10: idx=%0d data=%h, want 10 %h",
               dump_index, dump_data, exp_reg[10]);
    end
    halt       = 1'b0;
    dump_ready = 1'b0;
    seen_done  = 0;
    step();
    checks++;
    if (dump_valid !== 1'b0 || dump_index !== '0 || dump_data !== '0) begin
      errors++;
      $display("FAIL abort_idle: v=%b idx=%0d data=%h, want 0 0 0",
               dump_valid, dump_index, dump_data);
    end
    for (int i = 0; i < 4; i++) begin
      if (dump_done !== 1'b0) seen_done++;
      step();
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_done: got %0d pulses, want 0", seen_done);
    end
  endtask

  task automatic test_reset_mid_dump();
    int c;
    int bad;
    halt       = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    c = 0;
    while (dump_index !== AW'(20) && c < 50) begin
      step();
      c++;
    end
    checks++;
    if (dump_index !== AW'(20)) begin
      errors++;
      $display("FAIL reset_reach20: idx=%0d, want 20", dump_index);
    end
    rst        = 1'b1;
    halt       = 1'b0;
    reg_write  = 1'b1;
    write_reg  = 9;
    write_data = 32'hFFFF_FFFF;
    step();
    rst        = 1'b0;
    reg_write  = 1'b0;
    dump_ready = 1'b0;
    checks++;
    if (dump_valid !== 1'b0 || dump_index !== '0 || dump_done !== 1'b0
        || dump_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: v=%b idx=%0d done=%b data=%h, want 0",
               dump_valid, dump_index, dump_done, dump_data);
    end
    bad = 0;
    for (int i = 0; i < NR; i++) begin
      rd1 = AW'(i);
      rd2 = AW'(i);
      #1;
      if (rdata1 !== '0 || rdata2 !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_regs: %0d nonzero, want 0", bad);
    end
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    halt       = 1'b0;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    rd1        = '0;
    rd2        = '0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_halt();
    test_dump();
    test_abort();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
